// File: rtl/anc_test_sequencer.sv
// Phase controller: counts sample ticks through ID passes, a guard gap and an ANC run.
// Latency: tick is seen 2 bclk after audio_rx_down is first sampled high; outputs are registered or decoded from state.
// Backpressure: none; start is ignored while busy, abort and rst always take effect on the next edge.
module anc_test_sequencer #(
    parameter int ID_LEN    = 4096,
    parameter int ID_PASSES = 4,
    parameter int GUARD_LEN = 64,
    parameter int ANC_LEN   = 4096,
    parameter int TIMEOUT   = 4096
) (
    input  logic        bclk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        audio_rx_down,
    output logic [11:0] cyc_cnt,
    output logic        ofz_ok,
    output logic [7:0]  pass_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_IDENT = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_ANC   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    // Terminal counts, sized to the counters they are compared against
    localparam logic [11:0] CYC_LAST    = 12'(ID_LEN - 1);
    localparam logic [7:0]  PASS_LAST   = 8'(ID_PASSES);
    localparam logic [12:0] GUARD_TC    = 13'(GUARD_LEN);
    localparam logic [12:0] ANC_TC      = 13'(ANC_LEN);
    localparam logic [16:0] TO_TC       = 17'(TIMEOUT);
    localparam logic        GUARD_SKIP  = (GUARD_LEN == 0);
    localparam logic        ANC_ENDLESS = (ANC_LEN == 0);

    // Frame strobe synchronizer and edge-detect history
    logic        aud_s1;
    logic        aud_s2;
    logic        aud_s3;
    logic        tick;

    // State and counters
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [11:0] cyc_nxt;
    logic [7:0]  pass_nxt;
    logic [12:0] smp_cnt;
    logic [12:0] smp_nxt;
    logic [15:0] to_cnt;
    logic [15:0] to_nxt;
    logic        done_nxt;

    // Incremented values and decodes
    logic [11:0] cyc_inc;
    logic [7:0]  pass_inc;
    logic [12:0] smp_inc;
    logic [16:0] to_inc;
    logic        run;
    logic        to_hit;

    // Bring the frame strobe into bclk and keep one extra bit for rising-edge detection
    always_ff @(posedge bclk) begin
        if (rst) begin
            aud_s1 <= 1'b0;
            aud_s2 <= 1'b0;
            aud_s3 <= 1'b0;
        end else begin
            aud_s1 <= audio_rx_down;
            aud_s2 <= aud_s1;
            aud_s3 <= aud_s2;
        end
    end

    // One sample tick per received frame
    assign tick = aud_s2 & ~aud_s3;

    // Common decodes: active phases, increments, and the tick watchdog terminal count
    always_comb begin
        run      = (state == ST_ARM) || (state == ST_IDENT) ||
                   (state == ST_GUARD) || (state == ST_ANC);
        cyc_inc  = cyc_cnt + 12'd1;
        pass_inc = pass_cnt + 8'd1;
        smp_inc  = smp_cnt + 13'd1;
        to_inc   = {1'b0, to_cnt} + 17'd1;
        // A tick in the same cycle as the terminal count wins; no error then
        to_hit   = run && !tick && (to_inc == TO_TC);
    end

    // Next-state and counter update; abort has top priority, then the watchdog, then per-phase work
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        pass_nxt  = pass_cnt;
        smp_nxt   = smp_cnt;
        done_nxt  = 1'b0;
        if (!run) begin
            to_nxt = 16'd0;
        end else if (tick) begin
            to_nxt = 16'd0;
        end else begin
            to_nxt = to_inc[15:0];
        end

        if (abort) begin
            state_nxt = ST_IDLE;
            cyc_nxt   = 12'd0;
            pass_nxt  = 8'd0;
            smp_nxt   = 13'd0;
            to_nxt    = 16'd0;
        end else if (to_hit) begin
            // Frames stopped arriving; park in ERR until start or abort
            state_nxt = ST_ERR;
            cyc_nxt   = 12'd0;
            smp_nxt   = 13'd0;
            to_nxt    = 16'd0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        state_nxt = ST_ARM;
                        cyc_nxt   = 12'd0;
                        pass_nxt  = 8'd0;
                        smp_nxt   = 13'd0;
                        to_nxt    = 16'd0;
                    end
                end
                ST_ARM: begin
                    // The arming tick is sample 0 of the first pass
                    if (tick) begin
                        state_nxt = ST_IDENT;
                        cyc_nxt   = 12'd0;
                    end
                end
                ST_IDENT: begin
                    if (tick) begin
                        if (cyc_cnt != CYC_LAST) begin
                            cyc_nxt = cyc_inc;
                        end else begin
                            cyc_nxt  = 12'd0;
                            pass_nxt = pass_inc;
                            if (pass_inc == PASS_LAST) begin
                                smp_nxt   = 13'd0;
                                state_nxt = GUARD_SKIP ? ST_ANC : ST_GUARD;
                            end
                        end
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        if (smp_inc == GUARD_TC) begin
                            state_nxt = ST_ANC;
                            smp_nxt   = 13'd0;
                        end else begin
                            smp_nxt = smp_inc;
                        end
                    end
                end
                ST_ANC: begin
                    // With ANC_LEN of zero the run only ends on abort or timeout
                    if (tick) begin
                        if (!ANC_ENDLESS && (smp_inc == ANC_TC)) begin
                            state_nxt = ST_IDLE;
                            smp_nxt   = 13'd0;
                            done_nxt  = 1'b1;
                        end else begin
                            smp_nxt = smp_inc;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cyc_nxt   = 12'd0;
                    pass_nxt  = 8'd0;
                    smp_nxt   = 13'd0;
                    to_nxt    = 16'd0;
                end
            endcase
        end
    end

    // Register state, counters and the completion pulse
    always_ff @(posedge bclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cyc_cnt  <= 12'd0;
            pass_cnt <= 8'd0;
            smp_cnt  <= 13'd0;
            to_cnt   <= 16'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc_cnt  <= cyc_nxt;
            pass_cnt <= pass_nxt;
            smp_cnt  <= smp_nxt;
            to_cnt   <= to_nxt;
            done     <= done_nxt;
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        busy   = run;
        ofz_ok = (state == ST_ANC);
        err    = (state == ST_ERR);
    end

endmodule

// File: doc/anc_test_sequencer.md
Name: anc_test_sequencer

Overview:
- Phase controller for the offline-identification / ANC playback test path.
- Counts audio sample frames and drives the ROM address `cyc_cnt` through a fixed number of identification passes.
- After the passes, inserts a guard gap, then raises `ofz_ok` for a fixed-length (or endless) ANC run.
- Its outputs feed the mic-playback test block: `cyc_cnt` → dn ROM address, `ofz_ok` → datapath select.

Parameters:
- ID_LEN, 4096, samples per identification pass; `cyc_cnt` wraps at ID_LEN-1 (2..4096).
- ID_PASSES, 4, number of identification passes (1..255).
- GUARD_LEN, 64, samples with `ofz_ok`=0 and `cyc_cnt`=0 between identification and ANC (0 = skip).
- ANC_LEN, 4096, samples in the ANC phase (0 = run until abort).
- TIMEOUT, 4096, bclk cycles without a sample tick before error (1..65535).

Ports:
- bclk  in  1  codec bit clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; begins a sequence from IDLE or ERR.
- abort  in  1  level-sampled; returns to IDLE from any state.
- audio_rx_down  in  1  one rising edge per received stereo frame; asynchronous to bclk phase.
- cyc_cnt  out  12  identification ROM address.
- ofz_ok  out  1  1 during ANC phase only.
- pass_cnt  out  8  identification passes completed in the current sequence.
- busy  out  1  1 in ARM/IDENT/GUARD/ANC.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky tick-timeout flag.

Behaviour:
- Clock and reset: one clock, `bclk`. Reset is synchronous and active-high on `rst`.
- Reset values: state=IDLE; `cyc_cnt`=0, `ofz_ok`=0, `pass_cnt`=0, `busy`=0, `done`=0, `err`=0; sync flops=0. `rst` overrides every other input, including mid-sequence.
- Tick generation:
  - `audio_rx_down` passes through a 2-flop synchronizer plus one history flop.
  - `tick` = s2 & ~s3: a one-cycle pulse 2 bclk cycles after the first bclk edge that samples `audio_rx_down` high.
- States: IDLE, ARM, IDENT, GUARD, ANC, ERR.
- IDLE:
  - Outputs are zero, except `err` holds 0.
  - `start`=1 & `abort`=0 → ARM; `pass_cnt`←0, timeout counter←0.
- ARM → IDENT on `tick`. That tick is sample 0: `cyc_cnt` stays 0.
- IDENT, on each `tick`:
  - If `cyc_cnt`≠ID_LEN-1: `cyc_cnt`+1.
  - Otherwise: `cyc_cnt`←0 and `pass_cnt`+1.
  - If the increment makes `pass_cnt`=ID_PASSES: → GUARD, or → ANC when GUARD_LEN=0.
- GUARD:
  - `cyc_cnt`=0, `ofz_ok`=0.
  - Internal sample counter counts ticks; after GUARD_LEN ticks → ANC.
- ANC:
  - `ofz_ok`=1 from the cycle of entry; `cyc_cnt` held 0.
  - Sample counter cleared on entry and counts ticks.
  - When it reaches ANC_LEN (ANC_LEN≠0): next cycle `ofz_ok`=0, `done`=1 for exactly one cycle, state → IDLE, `pass_cnt` retained.
- Timeout:
  - In ARM/IDENT/GUARD/ANC, a 16-bit counter increments every bclk and clears on `tick`.
  - Reaching TIMEOUT → ERR: `err`=1, `busy`=0, `ofz_ok`=0, `cyc_cnt`=0.
- ERR:
  - `err` stays 1.
  - `start` → ARM with `err` cleared.
  - `abort` → IDLE with `err` cleared.
- `abort`:
  - Wins over `start` and over `tick` in the same cycle.
  - Next state IDLE; `cyc_cnt`/`ofz_ok`/`pass_cnt` cleared; no `done`.
- `start` while `busy` is ignored.
- A `tick` coincident with a timeout terminal count counts as a tick; no error is raised.
- Counter widths: sample counter 13 bits; all compares are exact equality, no saturation needed.

Test Plan (ID_LEN=8, ID_PASSES=2, GUARD_LEN=3, ANC_LEN=5, TIMEOUT=100; a tick every 64 bclk unless stated):
1. Full sequence: `rst`, then `start` pulse.
   - `cyc_cnt` runs 0..7 twice; `pass_cnt` reaches 2.
   - 3 ticks with `ofz_ok`=0, then `ofz_ok`=1 for 5 ticks.
   - Then `done`=1 for 1 cycle, `busy`=0, `ofz_ok`=0.
2. Wrap boundary: check the tick at `cyc_cnt`=7 of pass 1.
   - Next value is 0 and `pass_cnt` becomes 1 in the same cycle.
   - No extra state change until the pass-2 wrap.
3. Abort mid-IDENT at `cyc_cnt`=4, asserted together with `start` and a tick.
   - IDLE next cycle; all outputs 0; `done` never pulses; later `start` restarts from `cyc_cnt`=0.
4. Timeout: stop ticks during ANC.
   - Exactly 100 bclk after the last tick, `err`=1, `ofz_ok`=0, `busy`=0.
   - A following `start` clears `err` and re-enters ARM.
5. Endless ANC: ANC_LEN=0, run 50 ticks in ANC.
   - `ofz_ok` stays 1, no `done`.
   - `abort` drops `ofz_ok` on the next cycle.
6. Reset mid-GUARD: assert `rst` for 1 cycle.
   - All outputs equal their reset values on the following cycle; `start` is ignored while `rst`=1.
